// File: rtl/vesp_ava_wb_pkg.sv
// Shared Wishbone fill-master types: bus widths and the fill FSM state encoding.
package vesp_ava_wb_pkg;

  localparam int WB_ADR_W      = 32;
  localparam int WB_DAT_W      = 32;
  localparam int WB_SEL_W      = 4;
  localparam int WB_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/vesp_ava_wb_watchdog.sv
// Bus watchdog: counts enabled cycles since the last clear and flags expiry on the TIMEOUT-th cycle.
module vesp_ava_wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (!expire_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vesp_ava_wb_fill_master.sv
// Wishbone classic write initiator that fills or ramps len words from a start address.
// Optional bus watchdog compiled in with VESP_AVA_WB_WATCHDOG_EN.
module vesp_ava_wb_fill_master
  import vesp_ava_wb_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [WB_ADR_W-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]    cmd_len_i,
  input  logic [WB_DAT_W-1:0] cmd_data_i,
  input  logic [WB_DAT_W-1:0] cmd_step_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [WB_ADR_W-1:0] wb_adr_o,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  output logic [WB_SEL_W-1:0] wb_sel_o,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [LEN_W-1:0]    words_o
);

  fill_state_t         state_q, state_d;
  logic [WB_ADR_W-1:0] adr_q, adr_d;
  logic [WB_DAT_W-1:0] dat_q, dat_d;
  logic [WB_DAT_W-1:0] step_q, step_d;
  logic [WB_SEL_W-1:0] sel_q, sel_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [LEN_W-1:0]    words_q, words_d;
  logic                err_q, err_d;
  logic                wd_expire;

`ifdef VESP_AVA_WB_WATCHDOG_EN
  vesp_ava_wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (state_q == XFER),
    .clr_i    (wb_ack_i || wb_err_i),
    .expire_o (wd_expire)
  );
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT != 0);
  assign wd_expire      = 1'b0;
`endif

  // Command handshake: a command transfers on a clock edge where cmd_valid_i and
  // cmd_ready_o are both high; ready is only offered in IDLE and is forced low in reset.
  assign cmd_ready_o = (state_q == IDLE) && !rst_i;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign wb_cyc_o    = (state_q == XFER);
  assign wb_stb_o    = (state_q == XFER);
  assign wb_we_o     = (state_q == XFER);
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign err_o       = err_q;
  assign words_o     = words_q;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    step_d  = step_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    words_d = words_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          adr_d   = {cmd_addr_i[WB_ADR_W-1:2], 2'b00};
          dat_d   = cmd_data_i;
          step_d  = cmd_step_i;
          sel_d   = cmd_sel_i;
          rem_d   = cmd_len_i;
          words_d = '0;
          err_d   = 1'b0;
          state_d = (cmd_len_i == '0) ? DONE : XFER;
        end
      end
      XFER: begin
        // A bus error (or watchdog expiry) wins over a simultaneous ack; that beat is not counted.
        if (wb_err_i || wd_expire) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (wb_ack_i) begin
          words_d = words_q + LEN_W'(1);
          adr_d   = adr_q + WB_ADR_W'(WB_WORD_BYTES);
          dat_d   = dat_q + step_q;
          rem_d   = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      step_q  <= '0;
      sel_q   <= '0;
      rem_q   <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      step_q  <= step_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      words_q <= words_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_vesp_ava_wb_fill_master.sv
// Directed bench for vesp_ava_wb_fill_master: Wishbone slave model, beat scoreboard, timing checks.
module tb_vesp_ava_wb_fill_master;

  localparam int LEN_W = 16;
  localparam int W     = 69;  // {we, sel, adr, dat}

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid_i = 1'b0;
  logic             cmd_ready_o;
  logic [31:0]      cmd_addr_i = '0;
  logic [LEN_W-1:0] cmd_len_i = '0;
  logic [31:0]      cmd_data_i = '0;
  logic [31:0]      cmd_step_i = '0;
  logic [3:0]       cmd_sel_i = '0;
  logic             wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0]      wb_adr_o, wb_dat_o;
  logic [3:0]       wb_sel_o;
  logic             wb_ack_i = 1'b0;
  logic             wb_err_i = 1'b0;
  logic             busy_o, done_o, err_o;
  logic [LEN_W-1:0] words_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];

  int ack_delay = 0;
  int err_beat  = -1;
  int wait_cnt  = 0;
  int beat_idx  = 0;
  bit never_ack = 1'b0;

  always #5 clk = ~clk;

  vesp_ava_wb_fill_master #(
    .LEN_W   (LEN_W),
    .TIMEOUT (10)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_len_i   (cmd_len_i),
    .cmd_data_i  (cmd_data_i),
    .cmd_step_i  (cmd_step_i),
    .cmd_sel_i   (cmd_sel_i),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_o    (wb_sel_o),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .words_o     (words_o)
  );

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Slave: after ack_delay wait cycles it acks the presented beat; err joins ack on beat err_beat.
  always @(posedge clk) begin
    #1;
    if (!rst && wb_cyc_o && wb_stb_o && !never_ack) begin
      if (wait_cnt >= ack_delay) begin
        wb_ack_i = 1'b1;
        wb_err_i = (beat_idx == err_beat);
        wait_cnt = 0;
        beat_idx++;
      end else begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wait_cnt++;
      end
    end else begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
    end
  end

  // Monitor mid-cycle: completed beats against the scoreboard, held beats stay stable.
  bit           prev_wait = 1'b0;
  logic [W-1:0] prev_val;
  always @(negedge clk) begin
    if (wb_cyc_o && wb_stb_o) begin
      if (prev_wait) check_eq("hold_beat", {wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}, prev_val);
      if (wb_ack_i && !wb_err_i) begin
        check_eq("beat_pending", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check_eq("beat", {wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}, exp_q.pop_front());
      end
      prev_wait = !wb_ack_i && !wb_err_i;
      prev_val  = {wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o};
    end else begin
      prev_wait = 1'b0;
      check_eq("idle_bus", {wb_stb_o, wb_we_o}, 0);
    end
  end

  task automatic push_beats(input logic [31:0] a, input logic [31:0] d, input logic [31:0] s,
                            input logic [3:0] sel, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b1, sel, a, d});
      a = a + 32'd4;
      d = d + s;
    end
  endtask

  // Returns at 1 ns after the accepting edge (cycle N+1).
  task automatic send_cmd(input logic [31:0] a, input int len, input logic [31:0] d,
                          input logic [31:0] s, input logic [3:0] sel);
    int t;
    @(negedge clk);
    cmd_addr_i  = a;
    cmd_len_i   = LEN_W'(len);
    cmd_data_i  = d;
    cmd_step_i  = s;
    cmd_sel_i   = sel;
    cmd_valid_i = 1'b1;
    wait_cnt    = 0;
    beat_idx    = 0;
    t = 0;
    while (!cmd_ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("accept_timeout", (t >= 100), 0);
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic finish_cmd(input string tag, input int exp_k, input int exp_words, input bit exp_err);
    int k;
    k = 1;
    while (!done_o && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq({tag, "_done_cycle"}, k, exp_k);
    check_eq({tag, "_words"}, words_o, exp_words);
    check_eq({tag, "_err"}, err_o, exp_err);
    check_eq({tag, "_cyc_at_done"}, wb_cyc_o, 0);
    @(posedge clk);
    #1;
    check_eq({tag, "_done_single"}, done_o, 0);
    check_eq({tag, "_ready_after"}, cmd_ready_o, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
    check_eq("rst_regs", {wb_adr_o, wb_dat_o, wb_sel_o}, 0);
    check_eq("rst_status", {cmd_ready_o, busy_o, done_o, err_o, words_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("ready_after_rst", cmd_ready_o, 1);

    // Fill, slave acks every cycle.
    push_beats(32'h1000, 32'hA5A5A5A5, 32'h0, 4'hF, 4);
    send_cmd(32'h1000, 4, 32'hA5A5A5A5, 32'h0, 4'hF);
    check_eq("fill_cyc_n1", {wb_cyc_o, busy_o, cmd_ready_o}, 3'b110);
    finish_cmd("fill", 5, 4, 0);

    // Ramp across the 32-bit address and data wrap; low address bits ignored.
    push_beats(32'hFFFFFFF8, 32'hFFFFFFFE, 32'h1, 4'h3, 3);
    send_cmd(32'hFFFFFFFB, 3, 32'hFFFFFFFE, 32'h1, 4'h3);
    finish_cmd("ramp", 4, 3, 0);

    // Three wait states per beat.
    ack_delay = 3;
    push_beats(32'h2000, 32'h11, 32'h10, 4'h5, 2);
    send_cmd(32'h2000, 2, 32'h11, 32'h10, 4'h5);
    finish_cmd("wait", 9, 2, 0);
    ack_delay = 0;

    // Error with ack on beat 3 of 5.
    err_beat = 2;
    push_beats(32'h3000, 32'h100, 32'h4, 4'hF, 2);
    send_cmd(32'h3000, 5, 32'h100, 32'h4, 4'hF);
    finish_cmd("err", 4, 2, 1);
    err_beat = -1;
    push_beats(32'h3100, 32'h55, 32'h0, 4'h1, 1);
    send_cmd(32'h3100, 1, 32'h55, 32'h0, 4'h1);
    check_eq("err_cleared", {err_o, words_o}, 0);
    finish_cmd("after_err", 2, 1, 0);

    // Zero-length command.
    send_cmd(32'h7000, 0, 32'h1, 32'h0, 4'hF);
    check_eq("len0_n1", {done_o, wb_cyc_o}, 2'b10);
    finish_cmd("len0", 1, 0, 0);

    // Command held valid during a busy burst is taken only back in IDLE.
    push_beats(32'h5000, 32'h7, 32'h0, 4'hF, 3);
    send_cmd(32'h5000, 3, 32'h7, 32'h0, 4'hF);
    cmd_addr_i  = 32'h6000;
    cmd_len_i   = LEN_W'(1);
    cmd_data_i  = 32'h99;
    cmd_step_i  = 32'h0;
    cmd_sel_i   = 4'hC;
    cmd_valid_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check_eq("held_ready_low", cmd_ready_o, 0);
      if (i < 4) begin
        @(posedge clk);
        #1;
      end
    end
    check_eq("held_done", done_o, 1);
    @(posedge clk);
    #1;
    check_eq("held_idle", {cmd_ready_o, busy_o}, 2'b10);
    push_beats(32'h6000, 32'h99, 32'h0, 4'hC, 1);
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    check_eq("held_accepted", {wb_cyc_o, wb_adr_o}, {1'b1, 32'h6000});
    finish_cmd("held", 2, 1, 0);

    // Reset asserted mid-burst, between clock edges.
    push_beats(32'h4000, 32'h0, 32'h1, 4'hF, 1);
    send_cmd(32'h4000, 8, 32'h0, 32'h1, 4'hF);
    @(posedge clk);
    #1;
    check_eq("rst_burst_beat2", {wb_cyc_o, wb_adr_o}, {1'b1, 32'h4004});
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_async_bus", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
    check_eq("rst_async_regs", {wb_adr_o, wb_dat_o, wb_sel_o}, 0);
    check_eq("rst_async_status", {cmd_ready_o, busy_o, done_o, err_o, words_o}, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check_eq("rst_no_done", done_o, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_release_ready", {cmd_ready_o, done_o}, 2'b10);

`ifdef VESP_AVA_WB_WATCHDOG_EN
    never_ack = 1'b1;
    send_cmd(32'h8000, 1, 32'h1, 32'h0, 4'hF);
    finish_cmd("watchdog", 11, 0, 1);
    never_ack = 1'b0;
`endif

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
